// File: rtl/cim_bitserial_array.sv
`default_nettype none
// ============================================================================
// Module   : cim_bitserial_array
// Brief    : DEPTH x CH bit-plane array with row write/read, one-cycle clear
//            and an internal bit-serial add sequencer (optional subtract when
//            the SUB_MODE_EN macro is defined).
// Revision : 1.0 - initial release
// ============================================================================
module cim_bitserial_array #(
    parameter int CH    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_row,
    input  logic [CH-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_row,
    output logic [CH-1:0] rd_data,
    input  logic          start,
    input  logic [AW-1:0] a_base,
    input  logic [AW-1:0] b_base,
    input  logic [AW-1:0] d_base,
    input  logic [LW-1:0] op_len,
    input  logic          op_sub,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ADD   = 2'd1,
        S_CARRY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [CH-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_a_ptr, r_b_ptr, r_d_ptr;
    logic [LW-1:0] r_remain;
    logic [CH-1:0] r_carry;

    logic          w_idle, w_clr, w_start, w_host_wr, w_host_rd;
    logic [CH-1:0] w_a_row, w_b_row, w_sum, w_cout, w_b_inv, w_carry_init;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [CH-1:0] w_wdata;

`ifdef SUB_MODE_EN
    logic r_sub;
    assign w_b_inv      = {CH{r_sub}};
    assign w_carry_init = {CH{op_sub}};
`else
    logic w_unused_op_sub;
    assign w_unused_op_sub = op_sub;
    assign w_b_inv         = '0;
    assign w_carry_init    = '0;
`endif

    // Row pointers step modulo DEPTH, which need not be a power of two.
    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_idle    = (r_state == S_IDLE);
    assign w_clr     = w_idle & clr;
    assign w_start   = w_idle & ~clr & start;
    assign w_host_wr = w_idle & ~clr & ~start & wr_en;
    assign w_host_rd = w_idle & ~clr & ~start & rd_en;

    assign w_a_row = r_mem[r_a_ptr];
    assign w_b_row = r_mem[r_b_ptr] ^ w_b_inv;
    assign w_sum   = w_a_row ^ w_b_row ^ r_carry;
    assign w_cout  = (w_a_row & w_b_row) | (w_a_row & r_carry) | (w_b_row & r_carry);

    always_comb begin
        w_we    = 1'b0;
        w_waddr = wr_row;
        w_wdata = wr_data;
        case (r_state)
            S_IDLE: w_we = w_host_wr;
            S_ADD: begin
                w_we    = 1'b1;
                w_waddr = r_d_ptr;
                w_wdata = w_sum;
            end
            S_CARRY: begin
                w_we    = 1'b1;
                w_waddr = r_d_ptr;
                w_wdata = r_carry;
            end
            default: w_we = 1'b0;
        endcase
    end

    // Reads take pre-edge contents, so a same-row read returns the old word.
    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        if (rst) begin
            rd_data <= '0;
        end else if (w_host_rd) begin
            rd_data <= r_mem[rd_row];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_carry  <= '0;
            r_a_ptr  <= '0;
            r_b_ptr  <= '0;
            r_d_ptr  <= '0;
            r_remain <= '0;
`ifdef SUB_MODE_EN
            r_sub    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_a_ptr  <= a_base;
                        r_b_ptr  <= b_base;
                        r_d_ptr  <= d_base;
                        r_remain <= op_len;
                        r_carry  <= w_carry_init;
`ifdef SUB_MODE_EN
                        r_sub    <= op_sub;
`endif
                        busy     <= 1'b1;
                        r_state  <= (op_len == '0) ? S_DONE : S_ADD;
                    end
                end
                S_ADD: begin
                    r_carry  <= w_cout;
                    r_a_ptr  <= f_inc(r_a_ptr);
                    r_b_ptr  <= f_inc(r_b_ptr);
                    r_d_ptr  <= f_inc(r_d_ptr);
                    r_remain <= r_remain - 1'b1;
                    if (r_remain == LW'(1)) r_state <= S_CARRY;
                end
                S_CARRY: r_state <= S_DONE;
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cim_bitserial_array.sv
`default_nettype none
// Testbench for cim_bitserial_array: directed vector table, corner sequences
// and randomized operations against a per-lane integer reference model.
module tb_cim_bitserial_array;
    localparam int CH    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LW    = 5;

    logic          clk = 1'b0;
    logic          rst, clr, wr_en, rd_en, start, op_sub;
    logic [AW-1:0] wr_row, rd_row, a_base, b_base, d_base;
    logic [CH-1:0] wr_data, rd_data;
    logic [LW-1:0] op_len;
    logic          busy, done;

    always #5 clk = ~clk;

    cim_bitserial_array #(.CH(CH), .DEPTH(DEPTH), .AW(AW), .LW(LW)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data),
        .start(start), .a_base(a_base), .b_base(b_base), .d_base(d_base),
        .op_len(op_len), .op_sub(op_sub), .busy(busy), .done(done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [CH-1:0] model [DEPTH];

    typedef struct {
        int         a;
        int         b;
        bit         sub;
        logic [7:0] exp [5];
    } vec_t;

    vec_t vecs [6];
    int   n_vec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear;
        for (int r = 0; r < DEPTH; r++) model[r] = '0;
    endtask

    task automatic host_write(input int row, input logic [CH-1:0] d);
        wr_en = 1'b1; wr_row = AW'(row); wr_data = d;
        tick;
        wr_en = 1'b0;
        model[row] = d;
    endtask

    task automatic read_row(input int row, output logic [CH-1:0] val);
        rd_en = 1'b1; rd_row = AW'(row);
        tick;
        rd_en = 1'b0;
        val = rd_data;
    endtask

    task automatic check_all(input string name);
        logic [CH-1:0] v;
        for (int r = 0; r < DEPTH; r++) begin
            read_row(r, v);
            check($sformatf("%s row%0d", name, r), 32'(v), 32'(model[r]));
        end
    endtask

    // Per lane: gather operands as integers, do the arithmetic, scatter bits back.
    task automatic model_op(input int a, input int b, input int d, input int len, input bit sub);
        int unsigned res [CH];
        int unsigned av, bv, mask;
        bit es;
`ifdef SUB_MODE_EN
        es = sub;
`else
        es = 1'b0;
`endif
        if (len == 0) return;
        mask = (32'd1 << len) - 1;
        for (int ln = 0; ln < CH; ln++) begin
            av = 0; bv = 0;
            for (int k = 0; k < len; k++) begin
                av |= 32'(model[(a + k) % DEPTH][ln]) << k;
                bv |= 32'(model[(b + k) % DEPTH][ln]) << k;
            end
            res[ln] = es ? av + ((~bv) & mask) + 1 : av + bv;
        end
        for (int k = 0; k <= len; k++)
            for (int ln = 0; ln < CH; ln++)
                model[(d + k) % DEPTH][ln] = res[ln][k];
    endtask

    task automatic run_op(input int a, input int b, input int d, input int len,
                          input bit sub, input string name);
        int cnt;
        a_base = AW'(a); b_base = AW'(b); d_base = AW'(d);
        op_len = LW'(len); op_sub = sub; start = 1'b1;
        tick;
        start = 1'b0;
        check({name, " busy"}, 32'(busy), 32'd1);
        cnt = 0;
        while (!done && cnt < 100) begin
            tick;
            cnt++;
        end
        check({name, " latency"}, cnt, (len == 0) ? 1 : len + 2);
        check({name, " busy_at_done"}, 32'(busy), 32'd0);
        tick;
        check({name, " done_pulse"}, 32'(done), 32'd0);
        model_op(a, b, d, len, sub);
    endtask

    initial begin
        logic [CH-1:0] v;
        int nd, len, a, b, d;
        bit sub;

        rst = 1'b1; clr = 0; wr_en = 0; rd_en = 0; start = 0; op_sub = 0;
        wr_row = 0; rd_row = 0; wr_data = 0; a_base = 0; b_base = 0; d_base = 0; op_len = 0;
        model_clear();
        tick; tick;
        rst = 1'b0;
        check("reset busy", 32'(busy), 0);
        check("reset done", 32'(done), 0);
        check("reset rd_data", 32'(rd_data), 0);
        check_all("reset");

        vecs[0] = '{5, 3, 1'b0, '{8'h00, 8'h00, 8'h00, 8'hFF, 8'h00}};
        vecs[1] = '{15, 1, 1'b0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF}};
        vecs[2] = '{0, 0, 1'b0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[3] = '{9, 9, 1'b0, '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF}};
        n_vec = 4;
`ifdef SUB_MODE_EN
        vecs[4] = '{5, 3, 1'b1, '{8'h00, 8'hFF, 8'h00, 8'h00, 8'hFF}};
        vecs[5] = '{3, 5, 1'b1, '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00}};
        n_vec = 6;
`endif
        for (int i = 0; i < n_vec; i++) begin
            for (int k = 0; k < 4; k++) begin
                host_write(k, ((vecs[i].a >> k) & 1) != 0 ? 8'hFF : 8'h00);
                host_write(4 + k, ((vecs[i].b >> k) & 1) != 0 ? 8'hFF : 8'h00);
            end
            run_op(0, 4, 8, 4, vecs[i].sub, $sformatf("tbl%0d", i));
            for (int r = 0; r < 5; r++) begin
                read_row(8 + r, v);
                check($sformatf("tbl%0d row%0d", i, 8 + r), 32'(v), 32'(vecs[i].exp[r]));
            end
        end

        // Lane 3 has B=0 while the others carry out of 15+1.
        for (int k = 0; k < 4; k++) host_write(k, 8'hFF);
        host_write(4, 8'hF7); host_write(5, 8'h00); host_write(6, 8'h00); host_write(7, 8'h00);
        run_op(0, 4, 8, 4, 1'b0, "lane3");
        for (int r = 8; r < 12; r++) begin
            read_row(r, v);
            check($sformatf("lane3 row%0d", r), 32'(v), 32'h08);
        end
        read_row(12, v);
        check("lane3 carry", 32'(v), 32'hF7);

        // Zero-length op writes nothing.
        run_op(0, 4, 8, 0, 1'b0, "len0");
        check_all("len0");

        // Wrap around the top of the array.
        for (int r = 0; r < DEPTH; r++) host_write(r, CH'($urandom));
        run_op(14, 0, 12, 4, 1'b0, "wrap");
        check_all("wrap");

        // Collision: same-row write and read returns old contents.
        host_write(6, 8'h3C);
        wr_en = 1; wr_row = 6; wr_data = 8'hC3; rd_en = 1; rd_row = 6;
        tick;
        wr_en = 0; rd_en = 0;
        check("collision old", 32'(rd_data), 32'h3C);
        model[6] = 8'hC3;
        read_row(6, v);
        check("collision new", 32'(v), 32'hC3);

        // Busy blocking of host accesses.
        read_row(5, v);
        a_base = 0; b_base = 4; d_base = 8; op_len = 4; op_sub = 0; start = 1;
        tick;
        start = 0;
        tick;
        wr_en = 1; wr_row = 3; wr_data = 8'hAA;
        tick;
        wr_en = 0; clr = 1;
        tick;
        clr = 0; start = 1; rd_en = 1; rd_row = 2;
        tick;
        start = 0; rd_en = 0;
        check("busy rd_hold", 32'(rd_data), 32'(model[5]));
        nd = 0;
        for (int i = 0; i < 14; i++) begin
            if (done) nd++;
            tick;
        end
        check("busy done_count", nd, 1);
        model_op(0, 4, 8, 4, 1'b0);
        check_all("busy");

        // clr wins over a simultaneous write.
        clr = 1; wr_en = 1; wr_row = 2; wr_data = 8'h55;
        tick;
        clr = 0; wr_en = 0;
        model_clear();
        check_all("clr");

        // Reset in the middle of an add.
        for (int r = 0; r < 8; r++) host_write(r, CH'($urandom));
        a_base = 0; b_base = 4; d_base = 8; op_len = 4; start = 1;
        tick;
        start = 0;
        tick;
        rst = 1;
        tick;
        rst = 0;
        check("midrst busy", 32'(busy), 0);
        check("midrst done", 32'(done), 0);
        check("midrst rd_data", 32'(rd_data), 0);
        model_clear();
        check_all("midrst");

        // Random operations with disjoint (or exactly in-place) fields.
        for (int it = 0; it < 25; it++) begin
            for (int w = 0; w < 3; w++) host_write($urandom_range(0, DEPTH - 1), CH'($urandom));
            len = $urandom_range(0, 5);
            a = $urandom_range(0, DEPTH - 1);
            sub = 1'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                d = a;
                b = (a + len + 1) % DEPTH;
            end else begin
                b = (a + len) % DEPTH;
                d = (b + len) % DEPTH;
            end
            run_op(a, b, d, len, sub, $sformatf("rnd%0d", it));
            check_all($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
